conv_window_addr_gen: RTL and testbench

Parametrised sliding-window address generator for the convolution datapath. Walks a KxK kernel window over a multi-channel feature map held in a single linear memory, with programmable stride, and emits one read address per beat on a valid/ready stream. It supersedes the fixed single-channel, stride-1 address controller. It feeds the large-image BRAM read port and the MAC accumulator, which uses `win_last` to close each dot product.

---
 rtl/conv_window_addr_gen_pkg.sv | 15 +
 rtl/conv_window_addr_gen_wrap_counter.sv | 23 ++
 rtl/conv_window_addr_gen.sv | 199 +++++++++++++++++++
 tb/tb_conv_window_addr_gen.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/conv_window_addr_gen_pkg.sv
// Shared types and default widths for the convolution window address generator.
package conv_pkg;

  localparam int ADDR_W = 18;
  localparam int DIM_W  = 9;
  localparam int K_W    = 4;
  localparam int CH_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/conv_window_addr_gen_wrap_counter.sv
// Loop counter that counts 0..max and wraps; wrap flags the increment that rolls it over.
module wrap_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] max,
  output logic [W-1:0] value,
  output logic         wrap
);

  assign wrap = inc && (value == max);

  always_ff @(posedge clk) begin
    if (clr) begin
      value <= '0;
    end else if (inc) begin
      value <= wrap ? '0 : value + W'(1);
    end
  end

endmodule

// File: rtl/conv_window_addr_gen.sv
// Sliding KxK window address generator over a multi-channel linear feature map.
// Handshake: a beat transfers on a rising edge where out_valid && out_ready; nothing advances otherwise.
module conv_window_addr_gen #(
  parameter int ADDR_W = conv_pkg::ADDR_W,
  parameter int DIM_W  = conv_pkg::DIM_W,
  parameter int K_W    = conv_pkg::K_W,
  parameter int CH_W   = conv_pkg::CH_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DIM_W-1:0]  img_w,
  input  logic [DIM_W-1:0]  img_h,
  input  logic [K_W-1:0]    k_size,
  input  logic [K_W-1:0]    stride,
  input  logic [CH_W-1:0]   num_ch,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] address,
  output logic              win_last,
  output logic              busy,
  output logic              conv_done,
  output logic              cfg_err,
  output conv_pkg::state_t  state_dbg
);

  import conv_pkg::*;

  localparam int PW = 2 * DIM_W;
  localparam int SW = K_W + DIM_W;

  state_t state, state_n;

  logic [DIM_W-1:0] img_w_r, img_h_r;
  logic [K_W-1:0]   k_r, s_r;
  logic [CH_W-1:0]  c_r;
  logic             err_r;

  logic accept, bad, beat, clr;

  assign accept = (state == IDLE) && start;
  assign bad    = (k_size == '0) || (stride == '0) || (num_ch == '0) ||
                  (DIM_W'(k_size) > img_w) || (DIM_W'(k_size) > img_h);
  assign beat   = (state == RUN) && out_ready;
  assign clr    = reset || accept;

  // Loop maxima; the stride divisor is forced non-zero so idle garbage never divides by zero.
  logic [K_W-1:0]   k_max, s_div;
  logic [CH_W-1:0]  c_max;
  logic [DIM_W-1:0] ow_max, oh_max;

  assign k_max  = k_r - K_W'(1);
  assign c_max  = c_r - CH_W'(1);
  assign s_div  = (s_r == '0) ? K_W'(1) : s_r;
  assign ow_max = (img_w_r - DIM_W'(k_r)) / DIM_W'(s_div);
  assign oh_max = (img_h_r - DIM_W'(k_r)) / DIM_W'(s_div);

  logic [K_W-1:0]   kx, ky;
  logic [CH_W-1:0]  ch;
  logic [DIM_W-1:0] ox, oy;
  logic             kx_wrap, ky_wrap, ch_wrap, ox_wrap, oy_wrap;

  wrap_counter #(.W(K_W))   u_kx (.clk(clk), .clr(clr), .inc(beat),    .max(k_max),  .value(kx), .wrap(kx_wrap));
  wrap_counter #(.W(K_W))   u_ky (.clk(clk), .clr(clr), .inc(kx_wrap), .max(k_max),  .value(ky), .wrap(ky_wrap));
  wrap_counter #(.W(CH_W))  u_ch (.clk(clk), .clr(clr), .inc(ky_wrap), .max(c_max),  .value(ch), .wrap(ch_wrap));
  wrap_counter #(.W(DIM_W)) u_ox (.clk(clk), .clr(clr), .inc(ch_wrap), .max(ow_max), .value(ox), .wrap(ox_wrap));
  wrap_counter #(.W(DIM_W)) u_oy (.clk(clk), .clr(clr), .inc(ox_wrap), .max(oh_max), .value(oy), .wrap(oy_wrap));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = bad ? DONE : RUN;
      RUN:     if (oy_wrap) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      img_w_r <= '0;
      img_h_r <= '0;
      k_r     <= '0;
      s_r     <= '0;
      c_r     <= '0;
      err_r   <= 1'b0;
    end else if (accept) begin
      img_w_r <= img_w;
      img_h_r <= img_h;
      k_r     <= k_size;
      s_r     <= stride;
      c_r     <= num_ch;
      err_r   <= bad;
    end
  end

  // Address accumulators: each holds the address at the start of its loop level,
  // so a wrap at one level reloads every inner level from the next outer base.
  logic [PW-1:0]     hw_full;
  logic [SW-1:0]     sw_full;
  logic [ADDR_W-1:0] hw, sw, w_step, s_step;
  logic [ADDR_W-1:0] addr_q, line_q, chan_q, win_q, row_q;
  logic [ADDR_W-1:0] line_nx, chan_nx, win_nx, row_nx;

  assign hw_full = {{DIM_W{1'b0}}, img_h_r} * {{DIM_W{1'b0}}, img_w_r};
  assign sw_full = {{DIM_W{1'b0}}, s_r} * {{K_W{1'b0}}, img_w_r};
  assign hw      = ADDR_W'(hw_full);
  assign sw      = ADDR_W'(sw_full);
  assign w_step  = ADDR_W'(img_w_r);
  assign s_step  = ADDR_W'(s_r);
  assign line_nx = line_q + w_step;
  assign chan_nx = chan_q + hw;
  assign win_nx  = win_q + s_step;
  assign row_nx  = row_q + sw;

  always_ff @(posedge clk) begin
    if (clr) begin
      addr_q <= '0;
      line_q <= '0;
      chan_q <= '0;
      win_q  <= '0;
      row_q  <= '0;
    end else if (beat) begin
      if (!kx_wrap) begin
        addr_q <= addr_q + ADDR_W'(1);
      end else if (!ky_wrap) begin
        line_q <= line_nx;
        addr_q <= line_nx;
      end else if (!ch_wrap) begin
        chan_q <= chan_nx;
        line_q <= chan_nx;
        addr_q <= chan_nx;
      end else if (!ox_wrap) begin
        win_q  <= win_nx;
        chan_q <= win_nx;
        line_q <= win_nx;
        addr_q <= win_nx;
      end else if (!oy_wrap) begin
        row_q  <= row_nx;
        win_q  <= row_nx;
        chan_q <= row_nx;
        line_q <= row_nx;
        addr_q <= row_nx;
      end else begin
        addr_q <= '0;
        line_q <= '0;
        chan_q <= '0;
        win_q  <= '0;
        row_q  <= '0;
      end
    end
  end

  // win_last is registered, so it is predicted from the counter values after this beat.
  logic [K_W-1:0]  kx_n, ky_n;
  logic [CH_W-1:0] ch_n;
  logic            win_last_q, valid_q;

  always_comb begin
    kx_n = kx_wrap ? '0 : kx + K_W'(1);
    ky_n = ky;
    if (ky_wrap)      ky_n = '0;
    else if (kx_wrap) ky_n = ky + K_W'(1);
    ch_n = ch;
    if (ch_wrap)      ch_n = '0;
    else if (ky_wrap) ch_n = ch + CH_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      win_last_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= (state_n == RUN);
      if (accept) begin
        win_last_q <= !bad && (k_size == K_W'(1)) && (num_ch == CH_W'(1));
      end else if (beat) begin
        win_last_q <= !oy_wrap && (kx_n == k_max) && (ky_n == k_max) && (ch_n == c_max);
      end
    end
  end

  assign out_valid = valid_q;
  assign address   = addr_q;
  assign win_last  = win_last_q;
  assign busy      = (state != IDLE);
  assign conv_done = (state == DONE);
  assign cfg_err   = (state == DONE) && err_r;
  assign state_dbg = state;

endmodule

// File: tb/tb_conv_window_addr_gen.sv
// Directed bench for conv_window_addr_gen: table of job configs checked against a formula model.
module tb_conv_window_addr_gen;

  localparam int ADDR_W = 18;
  localparam int DIM_W  = 9;
  localparam int K_W    = 4;
  localparam int CH_W   = 4;

  logic              clk;
  logic              reset;
  logic              start;
  logic [DIM_W-1:0]  img_w, img_h;
  logic [K_W-1:0]    k_size, stride;
  logic [CH_W-1:0]   num_ch;
  logic              out_valid, out_ready;
  logic [ADDR_W-1:0] address;
  logic              win_last, busy, conv_done, cfg_err;
  conv_pkg::state_t  state_dbg;

  conv_window_addr_gen dut (
    .clk(clk), .reset(reset), .start(start),
    .img_w(img_w), .img_h(img_h), .k_size(k_size), .stride(stride), .num_ch(num_ch),
    .out_valid(out_valid), .out_ready(out_ready), .address(address), .win_last(win_last),
    .busy(busy), .conv_done(conv_done), .cfg_err(cfg_err), .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int w, h, k, s, c;
    int beats;
    int last_addr;
    bit err;
  } vec_t;

  vec_t vecs[10];
  logic [ADDR_W:0] exp_q[$];
  int total_cnt = 0;
  int pass_cnt  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference sequence straight from the address formula, loops kx innermost.
  task automatic build_model(input vec_t v);
    int ow, oh, a;
    logic [ADDR_W-1:0] am;
    logic lst;
    exp_q.delete();
    if (v.err) return;
    ow = (v.w - v.k) / v.s + 1;
    oh = (v.h - v.k) / v.s + 1;
    for (int oy = 0; oy < oh; oy++)
      for (int ox = 0; ox < ow; ox++)
        for (int ch = 0; ch < v.c; ch++)
          for (int ky = 0; ky < v.k; ky++)
            for (int kx = 0; kx < v.k; kx++) begin
              a   = ch * v.h * v.w + (oy * v.s + ky) * v.w + (ox * v.s + kx);
              am  = a[ADDR_W-1:0];
              lst = (kx == v.k - 1) && (ky == v.k - 1) && (ch == v.c - 1);
              exp_q.push_back({lst, am});
            end
  endtask

  task automatic drive_cfg(input vec_t v);
    img_w  = DIM_W'(v.w);
    img_h  = DIM_W'(v.h);
    k_size = K_W'(v.k);
    stride = K_W'(v.s);
    num_ch = CH_W'(v.c);
  endtask

  task automatic run_job(input int idx, input bit bp);
    vec_t v;
    int beats, last_beat_it, done_it, last_addr;
    bit stall, pulsed;
    logic [ADDR_W-1:0] prev_addr;
    logic prev_wl;
    logic [ADDR_W:0] e;
    v = vecs[idx];
    build_model(v);
    beats = 0; last_beat_it = -1; done_it = -1; last_addr = -1;
    stall = 1'b0; pulsed = 1'b0; prev_addr = '0; prev_wl = 1'b0;
    @(negedge clk);
    drive_cfg(v);
    start = 1'b1;
    out_ready = 1'b1;
    for (int it = 0; it < 4000; it++) begin
      @(negedge clk);
      start = 1'b0;
      if (conv_done) begin
        done_it = it;
        check($sformatf("v%0d_bp%0d_cfg_err", idx, bp), cfg_err, v.err);
        check($sformatf("v%0d_bp%0d_valid_in_done", idx, bp), out_valid, 0);
        check($sformatf("v%0d_bp%0d_busy_in_done", idx, bp), busy, 1);
        break;
      end
      if (stall) begin
        check($sformatf("v%0d_stall_addr", idx), address, prev_addr);
        check($sformatf("v%0d_stall_wl", idx), win_last, prev_wl);
      end
      stall = 1'b0;
      if (out_valid) begin
        out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            check($sformatf("v%0d_extra_beat", idx), beats, v.beats);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("v%0d_beat%0d_addr", idx, beats), address, e[ADDR_W-1:0]);
            check($sformatf("v%0d_beat%0d_win_last", idx, beats), win_last, e[ADDR_W]);
          end
          beats++;
          last_beat_it = it;
          last_addr = int'(address);
        end else begin
          stall = 1'b1;
          prev_addr = address;
          prev_wl = win_last;
        end
        if (bp && beats == 5 && !pulsed) begin
          start = 1'b1;
          k_size = K_W'(1);
          pulsed = 1'b1;
        end
      end else begin
        out_ready = 1'b1;
      end
    end
    check($sformatf("v%0d_bp%0d_done_seen", idx, bp), (done_it >= 0), 1);
    if (done_it >= 0)
      check($sformatf("v%0d_bp%0d_done_timing", idx, bp), done_it, v.err ? 0 : last_beat_it + 1);
    check($sformatf("v%0d_bp%0d_beat_count", idx, bp), beats, v.beats);
    check($sformatf("v%0d_bp%0d_model_left", idx, bp), exp_q.size(), 0);
    if (!v.err) check($sformatf("v%0d_bp%0d_last_addr", idx, bp), last_addr, v.last_addr);
    @(negedge clk);
    check($sformatf("v%0d_bp%0d_done_one_cycle", idx, bp), conv_done, 0);
    check($sformatf("v%0d_bp%0d_idle_busy", idx, bp), busy, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_addr"}, address, 0);
    check({tag, "_win_last"}, win_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_conv_done"}, conv_done, 0);
    check({tag, "_cfg_err"}, cfg_err, 0);
  endtask

  initial begin
    int cnt;
    bit seen_done;
    // w, h, k, s, c, beats, last_addr, err
    vecs[0] = '{4, 4, 3, 1, 1, 36, 15, 1'b0};
    vecs[1] = '{5, 5, 3, 2, 1, 36, 24, 1'b0};
    vecs[2] = '{3, 3, 3, 1, 2, 18, 17, 1'b0};
    vecs[3] = '{4, 4, 1, 1, 1, 16, 15, 1'b0};
    vecs[4] = '{5, 4, 2, 3, 3, 24, 49, 1'b0};
    vecs[5] = '{3, 5, 3, 1, 1, 27, 14, 1'b0};
    vecs[6] = '{4, 4, 5, 1, 1, 0, 0, 1'b1};
    vecs[7] = '{4, 4, 3, 0, 1, 0, 0, 1'b1};
    vecs[8] = '{4, 4, 2, 1, 0, 0, 0, 1'b1};
    vecs[9] = '{4, 4, 0, 1, 1, 0, 0, 1'b1};

    reset = 1'b1; start = 1'b0; out_ready = 1'b1;
    img_w = '0; img_h = '0; k_size = '0; stride = '0; num_ch = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    for (int i = 0; i < 10; i++) run_job(i, 1'b0);

    run_job(0, 1'b1);

    // Reset in the middle of a job, then the same job again from scratch.
    @(negedge clk);
    drive_cfg(vecs[0]);
    start = 1'b1;
    out_ready = 1'b1;
    cnt = 0;
    for (int it = 0; it < 200 && cnt < 10; it++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_valid) cnt++;
    end
    check("midrun_beats_before_reset", cnt, 10);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_all_zero("midrun_reset");
    seen_done = 1'b0;
    for (int it = 0; it < 5; it++) begin
      @(negedge clk);
      if (conv_done) seen_done = 1'b1;
    end
    check("midrun_no_done", seen_done, 0);
    run_job(0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
